// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and encodings for the memory/IO bus arbiter and its decoder.
package mem_bus_arbiter_pkg;

  // Default address map, inclusive bounds.
  localparam logic [31:0] USER_START = 32'h0000_0000;
  localparam logic [31:0] USER_END   = 32'h0000_0FFF;
  localparam logic [31:0] IO_START   = 32'h0000_1000;
  localparam logic [31:0] IO_END     = 32'h0000_1027;

  // Width of the wait-state counter; IO_WAIT is limited to 0..15.
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    RegRam,
    RegIo,
    RegNone
  } region_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

endpackage

// File: rtl/mem_bus_arbiter_region_decode.sv
// Combinational address-to-region classifier (RAM, IO or unmapped).
module region_decode #(
  parameter logic [31:0] USER_START = mem_bus_arbiter_pkg::USER_START,
  parameter logic [31:0] USER_END   = mem_bus_arbiter_pkg::USER_END,
  parameter logic [31:0] IO_START   = mem_bus_arbiter_pkg::IO_START,
  parameter logic [31:0] IO_END     = mem_bus_arbiter_pkg::IO_END
) (
  input  logic [31:0]                  addr_i,
  output mem_bus_arbiter_pkg::region_e region_o
);
  import mem_bus_arbiter_pkg::*;

  // Offset-from-base form gives an inclusive unsigned range check with a single compare
  // (assumes END >= START for each region).
  logic [31:0] user_off, io_off;
  assign user_off = addr_i - USER_START;
  assign io_off   = addr_i - IO_START;

  // Classify; RAM is checked first should the regions ever overlap.
  always_comb begin
    region_o = RegNone;
    if (user_off <= (USER_END - USER_START)) begin
      region_o = RegRam;
    end else if (io_off <= (IO_END - IO_START)) begin
      region_o = RegIo;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared memory/IO bus with region-dependent wait states.
// Optional feature: define ARB_RR_EN for round-robin arbitration; otherwise master 0 has
// fixed priority.
module mem_bus_arbiter #(
  parameter int unsigned IO_WAIT    = 2,
  parameter logic [31:0] USER_START = mem_bus_arbiter_pkg::USER_START,
  parameter logic [31:0] USER_END   = mem_bus_arbiter_pkg::USER_END,
  parameter logic [31:0] IO_START   = mem_bus_arbiter_pkg::IO_START,
  parameter logic [31:0] IO_END     = mem_bus_arbiter_pkg::IO_END
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        memCe,
  output logic        memWr,
  output logic [31:0] memAddr,
  output logic [31:0] wtData,
  input  logic [31:0] rdData
);
  import mem_bus_arbiter_pkg::*;

  localparam logic [CntW-1:0] IoWaitCnt = CntW'(IO_WAIT);

  state_e          state_q, state_d;
  region_e         region_q, region_d, sel_region;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_ce_q, mem_ce_d, mem_wr_q, mem_wr_d;
  logic [31:0]     mem_addr_q, mem_addr_d, wt_data_q, wt_data_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic            err0_q, err0_d, err1_q, err1_d;
  logic [31:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic            any_req, grant;
  logic            sel_we;
  logic [31:0]     sel_addr, sel_wdata, cap_data;

  assign any_req = m0_req | m1_req;

`ifdef ARB_RR_EN
  // Last-granted pointer: 1 means master 1 was granted last.
  logic last_q, last_d;

  // On contention grant the master that was not granted last.
  always_comb begin
    if (m0_req && m1_req) begin
      grant = ~last_q;
    end else begin
      grant = m1_req;
    end
    last_d = (state_q == StIdle && any_req) ? grant : last_q;
  end

  // Pointer resets to master 1 so master 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: master 1 only gets the bus when master 0 is not requesting.
  assign grant = ~m0_req;
`endif

  assign sel_we    = grant ? m1_we    : m0_we;
  assign sel_addr  = grant ? m1_addr  : m0_addr;
  assign sel_wdata = grant ? m1_wdata : m0_wdata;

  region_decode #(
    .USER_START (USER_START),
    .USER_END   (USER_END),
    .IO_START   (IO_START),
    .IO_END     (IO_END)
  ) u_region_decode (
    .addr_i   (sel_addr),
    .region_o (sel_region)
  );

  // Writes and unmapped accesses return zero read data.
  assign cap_data = (!we_q && region_q != RegNone) ? rdData : 32'h0;

  // Next-state logic; all outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    owner_d    = owner_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    mem_ce_d   = mem_ce_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    wt_data_d  = wt_data_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      StIdle: begin
        mem_ce_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_addr_d = 32'h0;
        wt_data_d  = 32'h0;
        if (any_req) begin
          owner_d  = grant;
          we_d     = sel_we;
          region_d = sel_region;
          cnt_d    = (sel_region == RegIo) ? IoWaitCnt : '0;
          // Unmapped addresses never touch the bus.
          if (sel_region != RegNone) begin
            mem_ce_d   = 1'b1;
            mem_wr_d   = sel_we;
            mem_addr_d = sel_addr;
            wt_data_d  = sel_wdata;
          end
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          mem_ce_d   = 1'b0;
          mem_wr_d   = 1'b0;
          mem_addr_d = 32'h0;
          wt_data_d  = 32'h0;
          if (owner_q) begin
            ack1_d   = 1'b1;
            err1_d   = (region_q == RegNone);
            rdata1_d = cap_data;
          end else begin
            ack0_d   = 1'b1;
            err0_d   = (region_q == RegNone);
            rdata0_d = cap_data;
          end
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      region_q   <= RegNone;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      mem_ce_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= 32'h0;
      wt_data_q  <= 32'h0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      mem_ce_q   <= mem_ce_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      wt_data_q  <= wt_data_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign memCe    = mem_ce_q;
  assign memWr    = mem_wr_q;
  assign memAddr  = mem_addr_q;
  assign wtData   = wt_data_q;
  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_err   = err0_q;
  assign m1_err   = err1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequential arbiter that shares the single memory/IO bus in front of the memory/IO decoder between two requesters: master 0 (CPU MEM-stage data port) and master 1 (DMA engine). It runs a req/ack handshake with each master, drives the decoder's chip-enable, write, address and data inputs for exactly one transfer at a time, and inserts region-dependent wait states. It returns captured read data and an error flag for unmapped addresses.

## Interface
- IO_WAIT, 2: extra ACCESS cycles for IO-region transfers (0..15)
- USER_START, 32'h0000_0000: first RAM address
- USER_END, 32'h0000_0FFF: last RAM address
- IO_START, 32'h0000_1000: first IO address
- IO_END, 32'h0000_1027: last IO address
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  transfer request, held until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid when ack = 1
- m0_err / m1_err  out  1  unmapped address, valid when ack = 1
- memCe  out  1  bus chip enable to decoder
- memWr  out  1  bus write enable
- memAddr  out  32  bus address
- wtData  out  32  bus write data
- rdData  in  32  bus read data from decoder

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if any req, pick owner, latch owner's we/addr/wdata, classify region (RAM, IO, NONE), load wait counter (RAM 0, IO IO_WAIT, NONE 0), go to ACCESS.
- ACCESS: memCe = 1 (0 for NONE), memWr = latched we, memAddr/wtData = latched values. Counter decrements each cycle; when counter = 0, capture rdData (reads only; writes capture 0), go to RESP.
- RESP: bus outputs return to 0; owner's ack = 1 with rdata/err; go to IDLE unconditionally.
- Non-owner's ack/err always 0; its rdata holds last value.
- Master must keep req, we, addr, wdata stable from assertion until ack; a req still high in the cycle after ack starts a new transfer.
- Region compare is unsigned and inclusive on both bounds; NONE gives err = 1, rdata = 0, no bus access.
- Both masters requesting in IDLE: resolved per Configuration.
- Reset asserted mid-transfer: all outputs drop to 0 asynchronously, transfer is abandoned, no ack. The owner must re-request.

## Timing
- Reset values: memCe, memWr, memAddr, wtData, all ack, err, rdata = 0. Priority pointer = master 1 last-granted.
- All outputs are registered. There is no combinational path from req or rdData to any output.
- Req seen in IDLE at cycle 0: memCe high from cycle 1.
- RAM: one ACCESS cycle, ack in cycle 2.
- IO: IO_WAIT+1 ACCESS cycles, ack in cycle 2+IO_WAIT.
- NONE: ack with err in cycle 2.
- rdData is sampled on the clock edge that ends the final ACCESS cycle.
- Maximum throughput is one transfer per 3 cycles for RAM, because RESP is followed by IDLE.

## Configuration
- ARB_RR_EN defined: round-robin. When both masters request, grant the one not granted last. The last-granted pointer updates on every grant.
- ARB_RR_EN undefined: fixed priority, master 0 always wins. The pointer logic is removed. Master 1 can starve while master 0 keeps requesting.

## Structure
- Shared package / define file: region bound constants USER_START/END and IO_START/END, the region encoding (RAM, IO, NONE), and the FSM state encoding.
- Sub-module `region_decode`: combinational address-to-region classifier, reusable by the decoder. The counter and FSM stay in the top module.

## Test plan
- RAM read, m0 only, addr 0x0000_0010, rdData = 0xDEADBEEF -> memCe high in cycle 1 only, m0_ack in cycle 2, m0_rdata = 0xDEADBEEF, m0_err = 0.
- IO write, m1 only, IO_WAIT = 2, addr 0x0000_1004, wdata 0x55 -> memCe = memWr = 1 for cycles 1–3 with wtData = 0x55, m1_ack in cycle 4.
- Unmapped read, addr 0x0000_2000 -> memCe stays 0, ack in cycle 2, err = 1, rdata = 0.
- Both masters hold req for 4 transfers -> ARB_RR_EN: grants m0, m1, m0, m1. Without the macro: m0 on all four, m1_ack never pulses.
- rst_n low during cycle 2 of an IO access -> memCe drops to 0 immediately, no ack, FSM in IDLE after release; the re-issued req completes normally.
